// File: rtl/nq_mem_sched.sv
// Purpose: sequences LW/SW/LB/SB and instruction fetch onto the single-ported 16-bit memory; data has priority, fetch is starvation-bounded.
// Latency: from the IDLE accept cycle, SW completes in cycle 1; LW, LB, SB and fetch complete in cycle 2.
// Backpressure: one access in flight; requests are only sampled in IDLE, so req simply waits until the block returns to IDLE.
module nq_mem_sched #(
    parameter int ADDR_W         = 16,
    parameter int FETCH_WAIT_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [15:0]       if_instr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [15:0]       d_wdata,
    output logic              d_done,
    output logic [15:0]       d_rdata,
    output logic [ADDR_W-2:0] mem_addr,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        F_RD   = 3'd1,
        F_CAP  = 3'd2,
        D_RD   = 3'd3,
        D_CAP  = 3'd4,
        D_WR   = 3'd5,
        RMW_RD = 3'd6,
        RMW_WR = 3'd7
    } state_t;

    localparam logic [2:0] WAIT_MAX = 3'(FETCH_WAIT_MAX);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              byte_q, byte_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [2:0]        starve_cnt_q, starve_cnt_d;

    logic              fetch_win;
    logic              data_win;

    // Arbitration: data wins a contested cycle unless fetch has already lost WAIT_MAX times in a row.
    always_comb begin
        fetch_win = if_req && (!d_req || (starve_cnt_q == WAIT_MAX));
        data_win  = d_req && !fetch_win;
    end

    // Next-state: pick the access flavour in IDLE, then walk the fixed read/capture/write sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fetch_win) begin
                    state_d = F_RD;
                end else if (data_win) begin
                    if (!d_we)       state_d = D_RD;
                    else if (d_byte) state_d = RMW_RD;
                    else             state_d = D_WR;
                end
            end
            F_RD:    state_d = F_CAP;
            D_RD:    state_d = D_CAP;
            RMW_RD:  state_d = RMW_WR;
            F_CAP,
            D_CAP,
            D_WR,
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and starvation counting, both only active in the IDLE arbitration cycle.
    always_comb begin
        addr_d       = addr_q;
        we_d         = we_q;
        byte_d       = byte_q;
        wdata_d      = wdata_q;
        starve_cnt_d = starve_cnt_q;
        if (state_q == IDLE) begin
            if (fetch_win) begin
                addr_d  = if_addr;
                we_d    = 1'b0;
                byte_d  = 1'b0;
                wdata_d = 16'h0000;
            end else if (data_win) begin
                addr_d  = d_addr;
                we_d    = d_we;
                byte_d  = d_byte;
                wdata_d = d_wdata;
            end
            if (fetch_win || !if_req) begin
                starve_cnt_d = 3'd0;
            end else if (data_win) begin
                starve_cnt_d = starve_cnt_q + 3'd1;
            end
        end
    end

    // State and latched-request registers; reset aborts any access in flight at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            byte_q       <= 1'b0;
            wdata_q      <= 16'h0000;
            starve_cnt_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            byte_q       <= byte_d;
            wdata_q      <= wdata_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Outputs decode from state and latched fields only, so no req input reaches an output combinationally.
    always_comb begin
        if_done   = 1'b0;
        if_instr  = 16'h0000;
        d_done    = 1'b0;
        d_rdata   = 16'h0000;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 16'h0000;
        busy      = (state_q != IDLE);
        if (state_q != IDLE) begin
            // Word accesses drop addr[0], which aligns odd word addresses down.
            mem_addr = addr_q[ADDR_W-1:1];
        end
        case (state_q)
            F_CAP: begin
                if_done  = 1'b1;
                if_instr = mem_rdata;
            end
            D_CAP: begin
                d_done = 1'b1;
                if (!byte_q)       d_rdata = mem_rdata;
                else if (addr_q[0]) d_rdata = {8'h00, mem_rdata[15:8]};
                else               d_rdata = {8'h00, mem_rdata[7:0]};
            end
            D_WR: begin
                d_done    = 1'b1;
                mem_we    = we_q;
                mem_wdata = wdata_q;
            end
            RMW_WR: begin
                // Merge the new byte into the word read back in RMW_RD.
                d_done = 1'b1;
                mem_we = we_q;
                if (addr_q[0]) mem_wdata = {wdata_q[7:0], mem_rdata[7:0]};
                else           mem_wdata = {mem_rdata[15:8], wdata_q[7:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nq_mem_sched.sv
// Directed bench for nq_mem_sched with a synchronous-read memory model.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Each step advances exactly one clock, so cycle numbers match the scheduler's latency counting.
module tb_nq_mem_sched;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_done;
    logic [15:0] if_instr;
    logic        d_req;
    logic        d_we;
    logic        d_byte;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_done;
    logic [15:0] d_rdata;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:32767];

    nq_mem_sched #(.ADDR_W(16), .FETCH_WAIT_MAX(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_instr (if_instr),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_byte   (d_byte),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-ported memory: write on the edge, registered read data for the next cycle.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Load from cycle 0 (accept) through completion, checking address, pulse and result.
    task automatic do_load(input string tag, input logic [15:0] addr, input logic is_byte,
                           input logic [14:0] exp_waddr, input logic [15:0] exp_data);
        d_req = 1'b1; d_we = 1'b0; d_byte = is_byte; d_addr = addr; d_wdata = 16'h0000;
        chk({tag, "_c0_busy"}, {31'd0, busy}, 32'd0);
        step();
        d_req = 1'b0;
        chk({tag, "_c1_addr"}, {17'd0, mem_addr}, {17'd0, exp_waddr});
        chk({tag, "_c1_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_c1_done"}, {31'd0, d_done}, 32'd0);
        step();
        chk({tag, "_c2_done"}, {31'd0, d_done}, 32'd1);
        chk({tag, "_c2_rdata"}, {16'd0, d_rdata}, {16'd0, exp_data});
        step();
        chk({tag, "_idle_done"}, {31'd0, d_done}, 32'd0);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int cyc;
        int if_pulses;
        int bad_pulses;
        logic [5:0] grants;

        rst = 1'b1;
        if_req = 1'b0; if_addr = 16'h0000;
        d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[5] = 16'hAFA0;
        mem[3] = 16'h080F;

        // Reset state
        step();
        step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {30'd0, if_done, d_done}, 32'd0);
        chk("rst_mem", {mem_we, mem_addr, mem_wdata}, 32'd0);
        chk("rst_data", {if_instr, d_rdata}, 32'd0);

        // Reset asserted mid-fetch drops everything immediately
        rst = 1'b0;
        if_req = 1'b1; if_addr = 16'h000B;
        step();
        chk("f0_rd_busy", {31'd0, busy}, 32'd1);
        chk("f0_rd_addr", {17'd0, mem_addr}, 32'h5);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_mem", {mem_we, mem_addr, mem_wdata}, 32'd0);
        chk("async_rst_done", {30'd0, if_done, d_done}, 32'd0);
        step();
        rst = 1'b0;
        // First request after release is accepted in this IDLE cycle
        chk("f1_c0_busy", {31'd0, busy}, 32'd0);
        step();
        chk("f1_c1_busy", {31'd0, busy}, 32'd1);
        chk("f1_c1_addr", {17'd0, mem_addr}, 32'h5);
        step();
        if_req = 1'b0;
        chk("f1_c2_done", {31'd0, if_done}, 32'd1);
        chk("f1_c2_instr", {16'd0, if_instr}, 32'hAFA0);
        step();
        chk("f1_idle_done", {31'd0, if_done}, 32'd0);
        chk("f1_idle_instr", {16'd0, if_instr}, 32'd0);

        // LW
        do_load("lw5", 16'h000A, 1'b0, 15'h5, 16'hAFA0);

        // SB to odd lane: read-modify-write
        d_req = 1'b1; d_we = 1'b1; d_byte = 1'b1; d_addr = 16'h0007; d_wdata = 16'h00F9;
        step();
        d_req = 1'b0;
        chk("sb_c1_we", {31'd0, mem_we}, 32'd0);
        chk("sb_c1_addr", {17'd0, mem_addr}, 32'h3);
        chk("sb_c1_done", {31'd0, d_done}, 32'd0);
        step();
        chk("sb_c2_we", {31'd0, mem_we}, 32'd1);
        chk("sb_c2_wdata", {16'd0, mem_wdata}, 32'hF90F);
        chk("sb_c2_done", {31'd0, d_done}, 32'd1);
        step();
        chk("sb_idle_we", {31'd0, mem_we}, 32'd0);
        do_load("lb7", 16'h0007, 1'b1, 15'h3, 16'h00F9);
        do_load("lb6", 16'h0006, 1'b1, 15'h3, 16'h000F);

        // SW completes in cycle 1; odd word load aligns down
        d_req = 1'b1; d_we = 1'b1; d_byte = 1'b0; d_addr = 16'h0010; d_wdata = 16'h8A5C;
        chk("sw_c0_we", {31'd0, mem_we}, 32'd0);
        step();
        d_req = 1'b0;
        chk("sw_c1_we", {31'd0, mem_we}, 32'd1);
        chk("sw_c1_addr", {17'd0, mem_addr}, 32'h8);
        chk("sw_c1_wdata", {16'd0, mem_wdata}, 32'h8A5C);
        chk("sw_c1_done", {31'd0, d_done}, 32'd1);
        step();
        chk("sw_c2_we", {31'd0, mem_we}, 32'd0);
        chk("sw_c2_done", {31'd0, d_done}, 32'd0);
        do_load("lw11", 16'h0011, 1'b0, 15'h8, 16'h8A5C);

        // Starvation bound: both requesters always pending
        if_req = 1'b1; if_addr = 16'h000A;
        d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 16'h0010;
        n = 0; cyc = 0; if_pulses = 0; grants = 6'b0;
        while (n < 6 && cyc < 60) begin
            step();
            cyc++;
            if (if_done) begin
                if_pulses++;
                grants[n] = 1'b1;
                n++;
                chk("starve_instr", {16'd0, if_instr}, 32'hAFA0);
                chk("starve_cnt_clr", {29'd0, dut.starve_cnt_q}, 32'd0);
            end else if (d_done) begin
                grants[n] = 1'b0;
                n++;
                chk("starve_rdata", {16'd0, d_rdata}, 32'h8A5C);
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("starve_ngrants", n, 32'd6);
        chk("starve_order", {26'd0, grants}, 32'b100100);
        chk("starve_ifdone_cnt", if_pulses, 32'd2);
        step();
        step();
        chk("starve_idle", {31'd0, busy}, 32'd0);

        // Reset during RMW_RD aborts the SB with no write and no completion
        mem[3] = 16'h080F;
        d_req = 1'b1; d_we = 1'b1; d_byte = 1'b1; d_addr = 16'h0007; d_wdata = 16'h0055;
        bad_pulses = 0;
        step();
        d_req = 1'b0;
        chk("abort_in_rmw", {31'd0, busy}, 32'd1);
        if (mem_we || d_done) bad_pulses++;
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_we", {31'd0, mem_we}, 32'd0);
        step();
        if (mem_we || d_done) bad_pulses++;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mem_we || d_done) bad_pulses++;
            step();
        end
        chk("abort_no_pulses", bad_pulses, 32'd0);
        chk("abort_word", {16'd0, mem[3]}, 32'h080F);
        chk("abort_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
